// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, opcode fields and the prefetch entry type
package fetch_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1111;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
  function automatic logic [3:0] opcode(input logic [DATA_W-1:0] w);
    return w[DATA_W-1:DATA_W-4];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous prefetch FIFO with single-cycle flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             rd_entry,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  assign rd_entry = (count != '0) ? mem[rd] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr] <= wr_entry;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + PW'(1);
      if (pop) rd <= rd + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, ROM reader and valid/ready prefetch front end
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int               DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0] count;
  logic push, pop;
  fetch_entry_t rd_entry;
  assign rom_addr = pc;
  assign inst_valid = count != '0;
  assign pop = inst_valid & inst_ready;
  assign push = fetch_en & ((count < CW'(DEPTH)) | pop) & ~redirect_valid;
  assign inst_data = rd_entry.data;
  assign inst_pc = rd_entry.pc;
  always_ff @(posedge clk) begin
    if (!rst_n) pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (push) pc <= pc + ADDR_W'(1);
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_entry('{data: rom_data, pc: pc}),
    .rd_entry(rd_entry),
    .count   (count)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized and directed checks against a queue-based fetch model
module tb_instruction_fetch;
  import fetch_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic fetch_en = 0;
  logic redirect_valid = 0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic inst_ready = 0;
  int checks = 0;
  int failures = 0;
  logic [15:0] rom [16];
  fetch_entry_t q[$];
  logic [ADDR_W-1:0] mpc;
  logic [36:0] obs, exp_v;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  task automatic step();
    bit do_pop, do_push;
    if (!rst_n) begin
      q.delete();
      mpc = '0;
    end else if (redirect_valid) begin
      q.delete();
      mpc = redirect_pc;
    end else begin
      do_pop = q.size() != 0 && inst_ready;
      do_push = fetch_en && (q.size() < 2 || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{data: rom[mpc], pc: mpc});
        mpc = mpc + 4'd1;
      end
    end
    @(posedge clk);
    #1;
    obs = {inst_valid, rom_addr, inst_valid ? {inst_data, inst_pc} : 20'h0, 12'h0};
    exp_v = {q.size() != 0, mpc, q.size() != 0 ? {q[0].data, q[0].pc} : 20'h0, 12'h0};
  endtask

  task automatic do_reset();
    rst_n = 0; redirect_valid = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    fetch_en = 1; inst_ready = 1;
    do_reset();
    checks++;
    if ({inst_valid, inst_data, inst_pc, rom_addr} !== 25'h0) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h pc=%h addr=%h want all zero", inst_valid, inst_data, inst_pc, rom_addr);
    end
  endtask

  task automatic test_stream();
    fetch_en = 1; inst_ready = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL stream_model cyc=%0d got %h want %h", i, obs, exp_v);
      end
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 4'(i) || inst_data !== rom[4'(i)]) begin
        failures++;
        $display("FAIL stream_seq cyc=%0d got v=%b pc=%h d=%h want pc=%h d=%h", i, inst_valid, inst_pc, inst_data, 4'(i), rom[4'(i)]);
      end
    end
  endtask

  task automatic test_stall();
    fetch_en = 1; inst_ready = 0;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (rom_addr !== 4'd2 || inst_valid !== 1'b1 || inst_pc !== 4'd0 || inst_data !== 16'h1203) begin
      failures++;
      $display("FAIL stall_hold got addr=%h v=%b pc=%h d=%h want addr=2 v=1 pc=0 d=1203", rom_addr, inst_valid, inst_pc, inst_data);
    end
    inst_ready = 1;
    for (int i = 1; i < 5; i++) begin
      step();
      checks++;
      if (obs !== exp_v || inst_pc !== 4'(i)) begin
        failures++;
        $display("FAIL stall_release cyc=%0d got %h pc=%h want %h pc=%h", i, obs, inst_pc, exp_v, 4'(i));
      end
    end
  endtask

  task automatic test_redirect();
    bit found = 0;
    fetch_en = 1; inst_ready = 1;
    do_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = inst_valid && inst_pc == 4'd4;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL redirect_wait got no pc4 within 40 cycles want pc4");
    end
    redirect_valid = 1; redirect_pc = 4'd10;
    step();
    redirect_valid = 0;
    checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 4'd10) begin
      failures++;
      $display("FAIL redirect_flush got v=%b addr=%h want v=0 addr=a", inst_valid, rom_addr);
    end
    for (int i = 10; i < 13; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 4'(i) || inst_data !== 16'hF000) begin
        failures++;
        $display("FAIL redirect_target got v=%b pc=%h d=%h want pc=%h d=f000", inst_valid, inst_pc, inst_data, 4'(i));
      end
    end
  endtask

  task automatic test_redirect_full();
    logic [ADDR_W-1:0] tgt;
    fetch_en = 1; inst_ready = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    tgt = 4'($urandom_range(5, 15));
    inst_ready = 1; redirect_valid = 1; redirect_pc = tgt;
    step();
    redirect_valid = 0;
    checks++;
    if (inst_valid !== 1'b0 || obs !== exp_v) begin
      failures++;
      $display("FAIL redirect_full_flush got %h want %h", obs, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== tgt + 4'(i) || obs !== exp_v) begin
        failures++;
        $display("FAIL redirect_full_stale got pc=%h v=%b want pc=%h", inst_pc, inst_valid, tgt + 4'(i));
      end
    end
  endtask

  task automatic test_fetch_en();
    fetch_en = 1; inst_ready = 0;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    fetch_en = 0; inst_ready = 1;
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 4'd1 || rom_addr !== 4'd2) begin
      failures++;
      $display("FAIL fetch_en_drain got v=%b pc=%h addr=%h want v=1 pc=1 addr=2", inst_valid, inst_pc, rom_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b0 || rom_addr !== 4'd2) begin
        failures++;
        $display("FAIL fetch_en_frozen got v=%b addr=%h want v=0 addr=2", inst_valid, rom_addr);
      end
    end
    fetch_en = 1;
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 4'd2 || inst_data !== 16'h2280) begin
      failures++;
      $display("FAIL fetch_en_resume got v=%b pc=%h d=%h want pc=2 d=2280", inst_valid, inst_pc, inst_data);
    end
  endtask

  task automatic test_midreset();
    fetch_en = 1; inst_ready = 1;
    do_reset();
    for (int i = 0; i < 7; i++) step();
    inst_ready = 0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 0;
    step();
    rst_n = 1;
    checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 4'd0) begin
      failures++;
      $display("FAIL midreset_clear got v=%b addr=%h want v=0 addr=0", inst_valid, rom_addr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 4'd0 || inst_data !== 16'h1203) begin
      failures++;
      $display("FAIL midreset_replay got v=%b pc=%h d=%h want pc=0 d=1203", inst_valid, inst_pc, inst_data);
    end
  endtask

  task automatic test_random();
    fetch_en = 1; inst_ready = 1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      fetch_en = $urandom_range(0, 3) != 0;
      inst_ready = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 11) == 0;
      redirect_pc = 4'($urandom);
      rst_n = $urandom_range(0, 63) != 0;
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL random_model cyc=%0d got %h want %h", i, obs, exp_v);
      end
    end
    rst_n = 1; redirect_valid = 0;
  endtask

  initial begin
    rom[0] = 16'h1203; rom[1] = 16'h1407; rom[2] = 16'h2280;
    for (int i = 3; i <= 9; i++) rom[i] = 16'hF200;
    for (int i = 10; i <= 14; i++) rom[i] = 16'hF000;
    rom[15] = 16'hF400;
    mpc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_fetch_en();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
